proj_idx_serializer: RTL and testbench



---
 rtl/proj_pkg.sv | 12 +
 rtl/proj_idx_serializer_if.sv | 31 +++
 rtl/proj_rise_detect.sv | 19 +
 rtl/proj_idx_serializer.sv | 144 ++++++++++++++
 tb/tb_proj_idx_serializer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/proj_pkg.sv
// Project-wide constants and types shared by the sorter/serializer/extender chain.
package proj_pkg;

    localparam int unsigned SORTER_EXTENDER_INDICES_COUNT = 4;
    localparam int unsigned INDICE_LEN                    = 8;
    localparam int unsigned SORTER_POSITION_LEN           = 2;

    typedef enum logic {SER_IDLE, SER_SEND} serializer_state_t;

    typedef logic [INDICE_LEN-1:0] index_t;

endpackage

// File: rtl/proj_idx_serializer_if.sv
// Serial index stream from the serializer toward the extender (valid/ready).
interface proj_idx_serializer_if
    import proj_pkg::*;
#(
    parameter int unsigned INDICE_LEN   = proj_pkg::INDICE_LEN,
    parameter int unsigned POSITION_LEN = SORTER_POSITION_LEN
);

    logic [INDICE_LEN-1:0]   out_index;
    logic [POSITION_LEN-1:0] out_position;
    logic                    out_valid;
    logic                    out_last;
    logic                    out_ready;

    modport master (
        output out_index,
        output out_position,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_index,
        input  out_position,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/proj_rise_detect.sv
// Registered rising-edge detector for level strobes (sort_valid, end_sorting).
module proj_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    // Remember last cycle's level so a held-high strobe yields one event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_prev <= 1'b0;
        else     r_prev <= i_level;
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/proj_idx_serializer.sv
// Captures the sorter's parallel K-smallest index vector on the rising edge of
// in_sort_valid and streams it out slot 0 first over a valid/ready interface.
// Optional: PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN adds a pending bank so a result
// arriving mid-stream is queued instead of dropped.
module proj_idx_serializer
    import proj_pkg::*;
#(
    parameter int unsigned INDICES_COUNT = SORTER_EXTENDER_INDICES_COUNT,
    parameter int unsigned INDICE_LEN    = proj_pkg::INDICE_LEN,
    parameter int unsigned POSITION_LEN  = SORTER_POSITION_LEN
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] in_smallest_idx,
    input  logic                                    in_sort_valid,
    proj_idx_serializer_if.master                   out_if,
    output logic                                    busy,
    output logic                                    overflow,
    input  logic                                    clr_overflow
);

    typedef logic [INDICES_COUNT-1:0][INDICE_LEN-1:0] bank_t;

    localparam logic [POSITION_LEN-1:0] LAST_SLOT = POSITION_LEN'(INDICES_COUNT - 1);

    serializer_state_t       r_state, w_state_nxt;
    logic [POSITION_LEN-1:0] r_slot,  w_slot_nxt;
    bank_t                   r_bank,  w_bank_nxt;
    logic                    r_overflow;
    logic                    w_overflow_nxt;
    logic                    w_ovf_set;
    logic                    w_rise;
    logic                    w_send;
    logic                    w_hs;
    logic                    w_final;
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
    bank_t                   r_pend,     w_pend_nxt;
    logic                    r_pend_vld, w_pend_vld_nxt;
`endif

    proj_rise_detect u_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (in_sort_valid),
        .o_rise  (w_rise)
    );

    assign w_send  = (r_state == SER_SEND);
    assign w_hs    = w_send & out_if.out_ready;
    assign w_final = w_hs & (r_slot == LAST_SLOT);

    // State, slot, bank and sticky overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SER_IDLE;
            r_slot     <= '0;
            r_bank     <= '0;
            r_overflow <= 1'b0;
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_slot     <= w_slot_nxt;
            r_bank     <= w_bank_nxt;
            r_overflow <= w_overflow_nxt;
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
`endif
        end
    end

    // Next-state: capture on edge, advance on handshake, reload on final handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_bank_nxt  = r_bank;
        w_ovf_set   = 1'b0;
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
`endif
        case (r_state)
            SER_IDLE: begin
                if (w_rise) begin
                    w_bank_nxt  = in_smallest_idx;
                    w_slot_nxt  = '0;
                    w_state_nxt = SER_SEND;
                end
            end
            SER_SEND: begin
                if (w_final) begin
                    w_slot_nxt = '0;
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
                    // Pending vector goes first; a coincident edge refills pending.
                    if (r_pend_vld) begin
                        w_bank_nxt     = r_pend;
                        w_pend_nxt     = in_smallest_idx;
                        w_pend_vld_nxt = w_rise;
                    end else if (w_rise) begin
                        w_bank_nxt = in_smallest_idx;
                    end else begin
                        w_state_nxt = SER_IDLE;
                    end
`else
                    if (w_rise) w_bank_nxt  = in_smallest_idx;
                    else        w_state_nxt = SER_IDLE;
`endif
                end else begin
                    if (w_hs) w_slot_nxt = r_slot + POSITION_LEN'(1);
                    if (w_rise) begin
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
                        if (!r_pend_vld) begin
                            w_pend_nxt     = in_smallest_idx;
                            w_pend_vld_nxt = 1'b1;
                        end else begin
                            w_ovf_set = 1'b1;
                        end
`else
                        w_ovf_set = 1'b1;
`endif
                    end
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
        // Set has priority over a same-cycle clear.
        w_overflow_nxt = w_ovf_set | (r_overflow & ~clr_overflow);
    end

    assign out_if.out_valid    = w_send;
    assign out_if.out_index    = w_send ? r_bank[r_slot] : '0;
    assign out_if.out_position = w_send ? r_slot : '0;
    assign out_if.out_last     = w_send & (r_slot == LAST_SLOT);
    assign overflow            = r_overflow;
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
    assign busy = w_send | r_pend_vld;
`else
    assign busy = w_send;
`endif

endmodule

// File: tb/tb_proj_idx_serializer.sv
// Directed self-checking bench for proj_idx_serializer (K=4, 8-bit indices).
module tb_proj_idx_serializer;
    import proj_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0][7:0] vec;
    logic           sv;
    logic           clr;
    logic           busy;
    logic           ovf;
    int             n_checks = 0;
    int             n_errors = 0;

    proj_idx_serializer_if #(.INDICE_LEN(8), .POSITION_LEN(2)) u_if ();

    proj_idx_serializer #(.INDICES_COUNT(4), .INDICE_LEN(8), .POSITION_LEN(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_smallest_idx (vec),
        .in_sort_valid   (sv),
        .out_if          (u_if.master),
        .busy            (busy),
        .overflow        (ovf),
        .clr_overflow    (clr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b want=0", u_if.out_valid); end
        n_checks++; if (u_if.out_last !== 1'b0) begin n_errors++; $display("FAIL reset_last got=%b want=0", u_if.out_last); end
        n_checks++; if (u_if.out_index !== 8'h00) begin n_errors++; $display("FAIL reset_index got=%h want=00", u_if.out_index); end
        n_checks++; if (u_if.out_position !== 2'd0) begin n_errors++; $display("FAIL reset_position got=%0d want=0", u_if.out_position); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got=%b want=0", ovf); end
        @(posedge clk); #1 rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        index_t exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        vec = {8'h44, 8'h33, 8'h22, 8'h11};
        u_if.out_ready = 1'b1;
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (u_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid slot%0d got=%b want=1", k, u_if.out_valid); end
            n_checks++; if (u_if.out_index !== exp[k]) begin n_errors++; $display("FAIL basic_index slot%0d got=%h want=%h", k, u_if.out_index, exp[k]); end
            n_checks++; if (u_if.out_position !== 2'(k)) begin n_errors++; $display("FAIL basic_position got=%0d want=%0d", u_if.out_position, k); end
            n_checks++; if (u_if.out_last !== (k == 3)) begin n_errors++; $display("FAIL basic_last slot%0d got=%b want=%b", k, u_if.out_last, (k == 3)); end
            n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy slot%0d got=%b want=1", k, busy); end
            cyc();
        end
        n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_valid_after got=%b want=0", u_if.out_valid); end
        n_checks++; if (u_if.out_last !== 1'b0) begin n_errors++; $display("FAIL basic_last_after got=%b want=0", u_if.out_last); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_after got=%b want=0", busy); end
        cyc();
    endtask

    task automatic test_backpressure();
        index_t exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int slot = 0;
        logic r;
        vec = {8'h44, 8'h33, 8'h22, 8'h11};
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        for (int c = 0; c < 20 && slot < 4; c++) begin
            r = (c % 3 == 0);
            u_if.out_ready = r;
            n_checks++; if (u_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid cyc%0d got=%b want=1", c, u_if.out_valid); end
            n_checks++; if (u_if.out_index !== exp[slot]) begin n_errors++; $display("FAIL bp_index cyc%0d got=%h want=%h", c, u_if.out_index, exp[slot]); end
            n_checks++; if (u_if.out_position !== 2'(slot)) begin n_errors++; $display("FAIL bp_position cyc%0d got=%0d want=%0d", c, u_if.out_position, slot); end
            cyc();
            if (r) slot++;
        end
        n_checks++; if (slot != 4) begin n_errors++; $display("FAIL bp_handshakes got=%0d want=4", slot); end
        n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL bp_valid_after got=%b want=0", u_if.out_valid); end
        u_if.out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_held_level();
        index_t exp[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        int hs = 0;
        vec = {8'h04, 8'h03, 8'h02, 8'h01};
        u_if.out_ready = 1'b1;
        sv = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (c == 5) sv = 1'b0;
            if (u_if.out_valid === 1'b1) begin
                if (hs < 4) begin
                    n_checks++; if (u_if.out_index !== exp[hs]) begin n_errors++; $display("FAIL held_index hs%0d got=%h want=%h", hs, u_if.out_index, exp[hs]); end
                end
                hs++;
            end
        end
        n_checks++; if (hs != 4) begin n_errors++; $display("FAIL held_stream_count got=%0d want=4", hs); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL held_overflow got=%b want=0", ovf); end
    endtask

    task automatic test_second_edge();
        logic [3:0][7:0] va = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        logic [3:0][7:0] vb = {8'hB4, 8'hB3, 8'hB2, 8'hB1};
        logic   exp_v[14];
        index_t exp_i[14];
        for (int s = 0; s < 14; s++) begin
            exp_v[s] = 1'b0;
            exp_i[s] = 8'h00;
            if (s < 4) begin exp_v[s] = 1'b1; exp_i[s] = va[s]; end
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
            if (s >= 4 && s < 8) begin exp_v[s] = 1'b1; exp_i[s] = vb[s-4]; end
`endif
        end
        vec = va;
        u_if.out_ready = 1'b1;
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        for (int s = 0; s < 14; s++) begin
            n_checks++; if (u_if.out_valid !== exp_v[s]) begin n_errors++; $display("FAIL second_valid s%0d got=%b want=%b", s, u_if.out_valid, exp_v[s]); end
            if (exp_v[s]) begin
                n_checks++; if (u_if.out_index !== exp_i[s]) begin n_errors++; $display("FAIL second_index s%0d got=%h want=%h", s, u_if.out_index, exp_i[s]); end
            end
            if (s == 3) begin
`ifdef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
                n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL second_overflow got=%b want=0", ovf); end
`else
                n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL second_overflow got=%b want=1", ovf); end
`endif
            end
            if (s == 1) begin vec = vb; sv = 1'b1; end
            if (s == 2) sv = 1'b0;
            cyc();
        end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL second_clear got=%b want=0", ovf); end
    endtask

    task automatic test_coincident();
        vec = {8'hC4, 8'hC3, 8'hC2, 8'hC1};
        u_if.out_ready = 1'b1;
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        cyc();
        cyc();
        cyc();
        n_checks++; if (u_if.out_last !== 1'b1) begin n_errors++; $display("FAIL coinc_last got=%b want=1", u_if.out_last); end
        vec = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        n_checks++; if (u_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL coinc_valid got=%b want=1", u_if.out_valid); end
        n_checks++; if (u_if.out_position !== 2'd0) begin n_errors++; $display("FAIL coinc_position got=%0d want=0", u_if.out_position); end
        n_checks++; if (u_if.out_index !== 8'hD1) begin n_errors++; $display("FAIL coinc_index got=%h want=d1", u_if.out_index); end
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL coinc_overflow got=%b want=0", ovf); end
        cyc();
        cyc();
        cyc();
        n_checks++; if (u_if.out_index !== 8'hD4) begin n_errors++; $display("FAIL coinc_tail_index got=%h want=d4", u_if.out_index); end
        cyc();
        n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL coinc_valid_after got=%b want=0", u_if.out_valid); end
    endtask

    task automatic test_reset_midstream();
        vec = {8'h5D, 8'h5C, 8'h5B, 8'h5A};
        u_if.out_ready = 1'b1;
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        cyc();
        cyc();
        n_checks++; if (u_if.out_position !== 2'd2) begin n_errors++; $display("FAIL rstmid_position got=%0d want=2", u_if.out_position); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_valid got=%b want=0", u_if.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        n_checks++; if (u_if.out_index !== 8'h00) begin n_errors++; $display("FAIL rstmid_index got=%h want=00", u_if.out_index); end
        @(posedge clk); #1 rst = 1'b0;
        vec = {8'h6D, 8'h6C, 8'h6B, 8'h6A};
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        n_checks++; if (u_if.out_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_restart_valid got=%b want=1", u_if.out_valid); end
        n_checks++; if (u_if.out_position !== 2'd0) begin n_errors++; $display("FAIL rstmid_restart_position got=%0d want=0", u_if.out_position); end
        n_checks++; if (u_if.out_index !== 8'h6A) begin n_errors++; $display("FAIL rstmid_restart_index got=%h want=6a", u_if.out_index); end
        for (int k = 0; k < 4; k++) cyc();
        n_checks++; if (u_if.out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_restart_end got=%b want=0", u_if.out_valid); end
    endtask

    task automatic test_overflow_clear();
        int n = 0;
        vec = {8'h74, 8'h73, 8'h72, 8'h71};
        u_if.out_ready = 1'b0;
        sv = 1'b1;
        cyc();
        sv = 1'b0;
        cyc();
        sv = 1'b1;
        cyc();
        sv = 1'b0;
`ifndef PROJ_IDX_SERIALIZER_DOUBLE_BUF_EN
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set got=%b want=1", ovf); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got=%b want=0", ovf); end
`endif
        cyc();
        sv = 1'b1;
        clr = 1'b1;
        cyc();
        sv = 1'b0;
        clr = 1'b0;
        n_checks++; if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set_beats_clear got=%b want=1", ovf); end
        n_checks++; if (u_if.out_index !== 8'h71) begin n_errors++; $display("FAIL ovf_stream_hold got=%h want=71", u_if.out_index); end
        n_checks++; if (u_if.out_position !== 2'd0) begin n_errors++; $display("FAIL ovf_stream_position got=%0d want=0", u_if.out_position); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_final_clear got=%b want=0", ovf); end
        u_if.out_ready = 1'b1;
        while (busy === 1'b1 && n < 20) begin cyc(); n++; end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL ovf_drain_timeout busy=%b want=0", busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sv = 1'b0;
        clr = 1'b0;
        vec = '0;
        u_if.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_held_level();
        test_second_edge();
        test_coincident();
        test_reset_midstream();
        test_overflow_clear();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
